// File: rtl/bike_fixed_weight_sampler_pkg.sv
// Shared types and helper functions for the fixed-weight sampler.
package bike_fixed_weight_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    EXPAND,
    DONE
  } sampler_state_t;

  function automatic int div_and_ceil(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Chunk-address width, never narrower than one bit.
  function automatic int log_chunks(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bike_fixed_weight_sampler_if.sv
// Random-index input stream and dense-chunk output stream of the sampler.
interface bike_fixed_weight_sampler_if #(
  parameter int B_WIDTH   = 32,
  parameter int LOGRBITS  = 14,
  parameter int LOGCHUNKS = 9
);

  logic [LOGRBITS-1:0]  rand_in;
  logic                 rand_valid;
  logic                 rand_ready;
  logic [B_WIDTH-1:0]   dout;
  logic [LOGCHUNKS-1:0] dout_addr;
  logic                 dout_valid;
  logic                 dout_ready;

  modport master (
    input  rand_in, rand_valid, dout_ready,
    output rand_ready, dout, dout_addr, dout_valid
  );

  modport slave (
    output rand_in, rand_valid, dout_ready,
    input  rand_ready, dout, dout_addr, dout_valid
  );

endinterface

// File: rtl/bike_fixed_weight_sampler_index_expander.sv
// Turns a list of set-bit positions into one dense chunk of the vector.
module bike_index_expander #(
  parameter int B_WIDTH   = 32,
  parameter int R_BITS    = 12323,
  parameter int WEIGHT    = 71,
  parameter int LOGRBITS  = 14,
  parameter int LOGCHUNKS = 9
) (
  input  logic [WEIGHT-1:0][LOGRBITS-1:0] indices,
  input  logic [WEIGHT-1:0]               valid,
  input  logic [LOGCHUNKS-1:0]            k,
  output logic [B_WIDTH-1:0]              chunk
);

  logic [31:0] base;
  logic [31:0] pos;

  // Each chunk bit is set when any valid index lands on its absolute position.
  always_comb begin
    chunk = '0;
    pos   = '0;
    base  = 32'(k) * 32'(B_WIDTH);
    for (int j = 0; j < B_WIDTH; j++) begin
      pos = base + 32'(j);
      for (int i = 0; i < WEIGHT; i++) begin
        if (valid[i] && (32'(indices[i]) == pos) && (pos < 32'(R_BITS))) begin
          chunk[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bike_fixed_weight_sampler.sv
// Fixed-weight sampler: collects WEIGHT distinct in-range positions from a
// random-index stream, then streams the dense vector out chunk by chunk.
module bike_fixed_weight_sampler
  import bike_fixed_weight_sampler_pkg::*;
#(
  parameter int B_WIDTH  = 32,
  parameter int R_BITS   = 12323,
  parameter int WEIGHT   = 71,
  parameter int LOGRBITS = $clog2(R_BITS)
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic busy,
  output logic done,
  bike_fixed_weight_sampler_if.master bus
);

  localparam int NUM_CHUNKS = div_and_ceil(R_BITS, B_WIDTH);
  localparam int LOGCHUNKS  = log_chunks(NUM_CHUNKS);
  localparam int CNTW       = $clog2(WEIGHT + 1);
  localparam logic [LOGCHUNKS-1:0] LAST_CHUNK = LOGCHUNKS'(NUM_CHUNKS - 1);

  sampler_state_t state, state_next;

  logic [CNTW-1:0]                 cnt, cnt_next;
  logic [WEIGHT-1:0][LOGRBITS-1:0] slots, slots_next;
  logic [WEIGHT-1:0]               slot_valid, slot_valid_next;
  logic [LOGCHUNKS-1:0]            k, k_next;
  logic [B_WIDTH-1:0]              dout_q;
  logic [B_WIDTH-1:0]              chunk_next;
  logic                            dup;
  logic                            in_range;

  // The expander looks at next-cycle slot contents and chunk index, so the
  // chunk registered on entry to EXPAND already includes the final index.
  bike_index_expander #(
    .B_WIDTH  (B_WIDTH),
    .R_BITS   (R_BITS),
    .WEIGHT   (WEIGHT),
    .LOGRBITS (LOGRBITS),
    .LOGCHUNKS(LOGCHUNKS)
  ) u_expander (
    .indices(slots_next),
    .valid  (slot_valid_next),
    .k      (k_next),
    .chunk  (chunk_next)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state, slot bookkeeping and output decode.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    slots_next      = slots;
    slot_valid_next = slot_valid;
    k_next          = k;
    in_range        = 32'(bus.rand_in) < 32'(R_BITS);
    dup             = 1'b0;

    for (int i = 0; i < WEIGHT; i++) begin
      if (slot_valid[i] && (slots[i] == bus.rand_in)) dup = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_next      = SAMPLE;
          cnt_next        = '0;
          slot_valid_next = '0;
          k_next          = '0;
        end
      end
      SAMPLE: begin
        k_next = '0;
        if (bus.rand_valid && in_range && !dup) begin
          for (int i = 0; i < WEIGHT; i++) begin
            if (i == int'(cnt)) begin
              slots_next[i]      = bus.rand_in;
              slot_valid_next[i] = 1'b1;
            end
          end
          cnt_next = cnt + CNTW'(1);
          if (32'(cnt) + 32'd1 == 32'(WEIGHT)) state_next = EXPAND;
        end
      end
      EXPAND: begin
        if (bus.dout_ready) begin
          if (k == LAST_CHUNK) state_next = DONE;
          else                 k_next     = k + LOGCHUNKS'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    bus.rand_ready = (state == SAMPLE);
    bus.dout_valid = (state == EXPAND);
    bus.dout_addr  = k;
    bus.dout       = dout_q;
    busy           = (state == SAMPLE) || (state == EXPAND);
    done           = (state == DONE);
  end

  // Datapath registers; dout only reloads while heading into or staying in EXPAND.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      slots      <= '0;
      slot_valid <= '0;
      k          <= '0;
      dout_q     <= '0;
    end else begin
      cnt        <= cnt_next;
      slots      <= slots_next;
      slot_valid <= slot_valid_next;
      k          <= k_next;
      if (state_next == EXPAND) dout_q <= chunk_next;
    end
  end

endmodule
